// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU arbiter: FSM state encoding,
// default ALU widths and the wrapping round-robin pointer increment.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_SW = 4;

    // Requester index after id, wrapping to 0 at n.
    function automatic int next_ptr(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted valid bit starting
// at ptr and wrapping at NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    always_comb begin
        int          j;
        logic [PW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            cand = PW'(j);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin
// fairness, an optional grant lock and a global chained carry flag.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int SW   = DEF_SW,
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ-1:0]    req_ci,
    input  logic [NREQ-1:0]    req_chain,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ*SW-1:0] req_sel,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_out,
    output logic               rsp_carry,
    output logic               rsp_z,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic               alu_ci,
    output logic [SW-1:0]      alu_sel,
    input  logic [DW-1:0]      alu_out,
    input  logic               alu_carry,
    input  logic               alu_z
);

    localparam int PW = $clog2(NREQ);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_id;
    logic [PW-1:0] lock_id;
    logic          lock_valid;
    logic          lock_req;
    logic          carry_flag;

    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic          grant_ok;
    logic [PW-1:0] grant_sel;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // A held lock overrides round-robin; if the owner is idle nobody is granted.
    always_comb begin
        grant_ok  = 1'b0;
        grant_sel = pick_idx;
        if (state == IDLE) begin
            if (lock_valid) begin
                grant_ok  = req_valid[lock_id];
                grant_sel = lock_id;
            end else begin
                grant_ok  = pick_found;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_ok) req_ready[grant_sel] = 1'b1;
        rsp_valid = '0;
        if (state == RESP) rsp_valid[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_id   <= '0;
            lock_id    <= '0;
            lock_valid <= 1'b0;
            lock_req   <= 1'b0;
            carry_flag <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ci     <= 1'b0;
            alu_sel    <= '0;
            rsp_out    <= '0;
            rsp_carry  <= 1'b0;
            rsp_z      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        alu_a    <= req_a[grant_sel*DW +: DW];
                        alu_b    <= req_b[grant_sel*DW +: DW];
                        alu_sel  <= req_sel[grant_sel*SW +: SW];
                        alu_ci   <= req_chain[grant_sel] ? carry_flag : req_ci[grant_sel];
                        grant_id <= grant_sel;
                        lock_req <= req_lock[grant_sel];
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_out    <= alu_out;
                    rsp_carry  <= alu_carry;
                    rsp_z      <= alu_z;
                    carry_flag <= alu_carry;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        state <= IDLE;
                        if (lock_req) begin
                            lock_valid <= 1'b1;
                            lock_id    <= grant_id;
                        end else begin
                            lock_valid <= 1'b0;
                            ptr        <= PW'(next_ptr(int'(grant_id), NREQ));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single operations plus
// hand-written sequences for contention, lock/chain, backpressure and reset.
module tb_alu_arbiter;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam int NREQ = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_ci;
    logic [NREQ-1:0]    req_chain;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*SW-1:0] req_sel;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_out;
    logic               rsp_carry;
    logic               rsp_z;
    logic [DW-1:0]      alu_a;
    logic [DW-1:0]      alu_b;
    logic               alu_ci;
    logic [SW-1:0]      alu_sel;
    logic [DW-1:0]      alu_out;
    logic               alu_carry;
    logic               alu_z;

    int checks;
    int errors;

    alu_arbiter #(.DW(DW), .SW(SW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .req_chain (req_chain),
        .req_lock  (req_lock),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry),
        .rsp_z     (rsp_z),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ci    (alu_ci),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_z     (alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: 0 add-with-carry, 1 and, 2 or, 3 xor, others pass a
    logic [8:0] sum9;
    always_comb begin
        sum9      = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_ci};
        alu_carry = 1'b0;
        case (alu_sel)
            4'd0: begin alu_out = sum9[7:0]; alu_carry = sum9[8]; end
            4'd1: alu_out = alu_a & alu_b;
            4'd2: alu_out = alu_a | alu_b;
            4'd3: alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a;
        endcase
        alu_z = (alu_out == 8'h00);
    end

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [3:0] sel;
        logic [7:0] eo;
        logic       ec;
        logic       ez;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic ci, input logic [3:0] sel,
                           input logic chain, input logic lock);
        req_a[id*DW +: DW]   = a;
        req_b[id*DW +: DW]   = b;
        req_sel[id*SW +: SW] = sel;
        req_ci[id]           = ci;
        req_chain[id]        = chain;
        req_lock[id]         = lock;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'h0);
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({nm, "_rsp_out"},   32'(rsp_out),   32'h0);
        chk({nm, "_rsp_carry"}, 32'(rsp_carry), 32'h0);
        chk({nm, "_rsp_z"},     32'(rsp_z),     32'h0);
        chk({nm, "_alu_a"},     32'(alu_a),     32'h0);
        chk({nm, "_alu_b"},     32'(alu_b),     32'h0);
        chk({nm, "_alu_ci"},    32'(alu_ci),    32'h0);
        chk({nm, "_alu_sel"},   32'(alu_sel),   32'h0);
    endtask

    // Issue one unlocked, unchained op on requester id with rsp_ready high.
    task automatic do_op(input vec_t v);
        logic [1:0] oh;
        int         n;
        oh = 2'b01 << v.id;
        @(negedge clk);
        set_req(v.id, v.a, v.b, v.ci, v.sel, 1'b0, 1'b0);
        req_valid[v.id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[v.id] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("op_req_ready", 32'(req_ready), 32'(oh));
        @(negedge clk);
        req_valid[v.id] = 1'b0;
        #1;
        chk("op_exec_alu_a",   32'(alu_a),   32'(v.a));
        chk("op_exec_alu_b",   32'(alu_b),   32'(v.b));
        chk("op_exec_alu_ci",  32'(alu_ci),  32'(v.ci));
        chk("op_exec_alu_sel", 32'(alu_sel), 32'(v.sel));
        chk("op_exec_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("op_rsp_valid", 32'(rsp_valid), 32'(oh));
        chk("op_rsp_out",   32'(rsp_out),   32'(v.eo));
        chk("op_rsp_carry", 32'(rsp_carry), 32'(v.ec));
        chk("op_rsp_z",     32'(rsp_z),     32'(v.ez));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        req_chain = '0;
        req_lock  = '0;
        req_sel   = '0;
        rsp_ready = 2'b11;

        vecs[0] = '{id: 0, a: 8'hAA, b: 8'h55, ci: 1'b1, sel: 4'd0, eo: 8'h00, ec: 1'b1, ez: 1'b1};
        vecs[1] = '{id: 1, a: 8'h12, b: 8'h34, ci: 1'b0, sel: 4'd0, eo: 8'h46, ec: 1'b0, ez: 1'b0};
        vecs[2] = '{id: 0, a: 8'hF0, b: 8'h3C, ci: 1'b0, sel: 4'd1, eo: 8'h30, ec: 1'b0, ez: 1'b0};
        vecs[3] = '{id: 1, a: 8'hF0, b: 8'h0F, ci: 1'b1, sel: 4'd1, eo: 8'h00, ec: 1'b0, ez: 1'b1};
        vecs[4] = '{id: 0, a: 8'hA0, b: 8'h05, ci: 1'b0, sel: 4'd2, eo: 8'hA5, ec: 1'b0, ez: 1'b0};
        vecs[5] = '{id: 1, a: 8'hFF, b: 8'hFF, ci: 1'b0, sel: 4'd3, eo: 8'h00, ec: 1'b0, ez: 1'b1};
        vecs[6] = '{id: 0, a: 8'h7F, b: 8'h80, ci: 1'b1, sel: 4'd0, eo: 8'h00, ec: 1'b1, ez: 1'b1};

        #12;
        chk_all_zero("reset");
        do_reset();

        foreach (vecs[i]) do_op(vecs[i]);

        // Contention: one grant every 3 cycles, alternating 0,1,0,1
        do_reset();
        @(negedge clk);
        set_req(0, 8'h01, 8'h02, 1'b0, 4'd0, 1'b0, 1'b0);
        set_req(1, 8'h03, 8'h04, 1'b0, 4'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 12; k++) begin
            chk("fair_req_ready", 32'(req_ready),
                (k % 3 != 0) ? 32'h0 : (((k / 3) % 2 == 0) ? 32'h1 : 32'h2));
            @(negedge clk);
            #1;
        end
        req_valid = 2'b00;

        // Lock plus chain: requester 1 holds the ALU for two ops
        do_reset();
        do_op('{id: 0, a: 8'h10, b: 8'h20, ci: 1'b0, sel: 4'd0, eo: 8'h30, ec: 1'b0, ez: 1'b0});
        @(negedge clk);
        set_req(0, 8'h10, 8'h20, 1'b0, 4'd0, 1'b0, 1'b0);
        set_req(1, 8'hFF, 8'h01, 1'b0, 4'd0, 1'b0, 1'b1);
        req_valid = 2'b11;
        #1;
        chk("lock_grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        set_req(1, 8'h00, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        chk("lock_exec1_a", 32'(alu_a), 32'hFF);
        chk("lock_exec1_ci", 32'(alu_ci), 32'h0);
        @(negedge clk);
        #1;
        chk("lock_rsp1_valid", 32'(rsp_valid), 32'h2);
        chk("lock_rsp1_out", 32'(rsp_out), 32'h00);
        chk("lock_rsp1_carry", 32'(rsp_carry), 32'h1);
        @(negedge clk);
        #1;
        chk("lock_grant2", 32'(req_ready), 32'h2);
        @(negedge clk);
        #1;
        chk("chain_exec_ci", 32'(alu_ci), 32'h1);
        chk("chain_exec_a", 32'(alu_a), 32'h00);
        @(negedge clk);
        #1;
        chk("chain_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("chain_rsp_out", 32'(rsp_out), 32'h01);
        chk("chain_rsp_carry", 32'(rsp_carry), 32'h0);
        chk("chain_rsp_z", 32'(rsp_z), 32'h0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        chk("unlock_grant0", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("unlock_exec0_a", 32'(alu_a), 32'h10);

        // Response backpressure for 5 cycles; other slice's rsp_ready ignored
        do_reset();
        rsp_ready = 2'b00;
        @(negedge clk);
        set_req(0, 8'hFF, 8'h02, 1'b0, 4'd0, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        set_req(1, 8'h05, 8'h06, 1'b0, 4'd0, 1'b0, 1'b0);
        req_valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rsp_ready = 2'b10;
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_out", 32'(rsp_out), 32'h01);
            chk("bp_rsp_carry", 32'(rsp_carry), 32'h1);
            chk("bp_rsp_z", 32'(rsp_z), 32'h0);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        @(negedge clk);
        rsp_ready = 2'b01;
        #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        #1;
        chk("bp_done_valid", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);

        // Asynchronous reset while in EXEC
        do_reset();
        @(negedge clk);
        set_req(0, 8'h33, 8'h44, 1'b1, 4'd2, 1'b0, 1'b0);
        req_valid = 2'b01;
        #1;
        chk("ar_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("ar_exec_a", 32'(alu_a), 32'h33);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("ar");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("ar_no_rsp", 32'(rsp_valid), 32'h0);
        end
        @(negedge clk);
        set_req(1, 8'h01, 8'h01, 1'b0, 4'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("ar_ptr0_grant", 32'(req_ready), 32'h1);

        // Locked requester goes idle: nobody else is granted
        do_reset();
        @(negedge clk);
        set_req(1, 8'h01, 8'h01, 1'b0, 4'd0, 1'b0, 1'b1);
        set_req(0, 8'h02, 8'h02, 1'b0, 4'd0, 1'b0, 1'b0);
        req_valid = 2'b10;
        #1;
        chk("li_grant1", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        chk("li_rsp", 32'(rsp_valid), 32'h2);
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 10; k++) begin
            chk("li_no_grant", 32'(req_ready), 32'h0);
            chk("li_no_rsp", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            #1;
        end
        set_req(1, 8'h01, 8'h01, 1'b0, 4'd0, 1'b0, 1'b0);
        req_valid = 2'b11;
        #1;
        chk("li_owner_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU (operands a/b, carry-in, 4-bit select; result, carry-out, zero flag) between NREQ requesters.
- Each requester issues operations with a valid/ready handshake and receives a registered result with a valid/ready handshake.
- A round-robin grant pointer provides fairness.
- A lock bit allows one requester to hold the ALU across a multi-byte sequence; a chain bit propagates the previous carry into the next operation.
- Sits between the ALU and the sequencing/control logic that today drives the ALU directly.

Parameters:
- DW, 8, ALU operand/result width.
- SW, 4, ALU select width; the opcode is opaque to this block.
- NREQ, 2, number of requesters (>=2); ports are packed per-requester vectors, requester i at slice i.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  request pending, per requester
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- req_a  in  NREQ*DW  operand a
- req_b  in  NREQ*DW  operand b
- req_ci  in  NREQ  carry-in, used when chain=0
- req_chain  in  NREQ  1 = use stored carry flag as carry-in
- req_lock  in  NREQ  1 = keep grant after this op completes
- req_sel  in  NREQ*SW  ALU select
- rsp_valid  out  NREQ  result available (one-hot or zero)
- rsp_ready  in  NREQ  requester takes result
- rsp_out  out  DW  result, shared bus, meaningful for the rsp_valid slice
- rsp_carry  out  1  carry-out of result
- rsp_z  out  1  zero flag of result
- alu_a  out  DW  to ALU operand a
- alu_b  out  DW  to ALU operand b
- alu_ci  out  1  to ALU carry-in
- alu_sel  out  SW  to ALU select
- alu_out  in  DW  from ALU result
- alu_carry  in  1  from ALU carry-out
- alu_z  in  1  from ALU zero flag

Behaviour:
- **Reset (async, rst=1):**
  - state=IDLE, ptr=0, lock_valid=0, carry_flag=0.
  - All outputs 0: req_ready, rsp_valid, rsp_out, rsp_carry, rsp_z, alu_a, alu_b, alu_ci, alu_sel.
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE:**
  - If lock_valid and req_valid[lock_id]: grant lock_id.
  - If lock_valid and requester lock_id is not valid: no grant; the ALU is held.
  - Else: grant the first valid requester searching from ptr upward, wrapping at NREQ.
  - On grant g:
    - req_ready[g]=1 for exactly this cycle; the handshake completes in this cycle.
    - Operand registers load a, b, sel, and ci = req_chain[g] ? carry_flag : req_ci[g].
    - grant_id=g, lock_req=req_lock[g]; go to EXEC.
  - No valid requests: stay in IDLE; req_ready=0.
- **EXEC (1 cycle):**
  - Operand registers drive the alu_* outputs; alu_* hold their values outside EXEC.
  - At the clock edge: capture alu_out/alu_carry/alu_z into rsp_out/rsp_carry/rsp_z; carry_flag<=alu_carry; go to RESP.
- **RESP:**
  - rsp_valid[grant_id]=1; rsp_* stable until the handshake.
  - On rsp_ready[grant_id]:
    - rsp_valid clears next cycle; go to IDLE.
    - If lock_req: lock_valid<=1, lock_id<=grant_id, ptr unchanged.
    - Else: lock_valid<=0, ptr<=grant_id+1 (wrap to 0 at NREQ).
  - rsp_ready on other slices is ignored.
- **Latency and throughput:**
  - Acceptance to rsp_valid is 2 cycles.
  - Minimum period is 3 cycles per op (IDLE, EXEC, RESP with same-cycle rsp_ready).
- **Request invariants:**
  - req_ready is asserted only in IDLE, so no new request is accepted while one is outstanding.
  - Requesters must hold their request fields stable while req_valid=1 and req_ready=0.
- **Simultaneous requests:** resolved purely by ptr/lock. After an unlocked grant to g, requester g has lowest priority in the next arbitration.
- **Lock release:** a locked requester releases by completing an op with req_lock=0.
- **Carry flag:**
  - Global; it is the carry-out of the most recently executed op by any requester.
  - Chained ops are only meaningful under lock.
- **Widths:** no arithmetic inside this block. ptr and grant_id are clog2(NREQ) bits, with explicit wrap.
- **Reset mid-operation:** any outstanding op is dropped, with no response; the lock is cleared.

Decomposition:
- **Package alu_arb_pkg:**
  - state enum (IDLE/EXEC/RESP).
  - Default DW/SW constants.
  - Helper function next_ptr(id) with wrap.
- **Sub-module rr_pick:** combinational round-robin first-valid-from-pointer search over NREQ; outputs a found bit and the index. All other logic stays in alu_arbiter.

Test Plan:
1. **Single op.**
   - Stimulus: after reset, requester 0 sends a=0xAA, b=0x55, ci=1, sel=0x0, chain=0.
   - Required: req_ready[0] pulses 1 cycle; alu_a=0xAA, alu_b=0x55, alu_ci=1 in EXEC; rsp_valid[0]=1 two cycles later with rsp_out/carry/z equal to the ALU model's output for sel=0.
2. **Contention fairness.**
   - Stimulus: requesters 0 and 1 both continuously valid, lock=0, rsp_ready tied 1.
   - Required: grants alternate 0,1,0,1, one grant every 3 cycles.
3. **Lock plus chain.**
   - Stimulus: requester 1 issues sel=add, a=0xFF, b=0x01, lock=1, then a=0x00, b=0x00, chain=1, lock=0, while requester 0 is continuously valid.
   - Required: requester 1 gets both grants back-to-back; second alu_ci=1, rsp_out=0x01; requester 0 is granted next.
4. **Response backpressure.**
   - Stimulus: rsp_ready[0]=0 for 5 cycles.
   - Required: state stays RESP; rsp_out/rsp_carry/rsp_z stable; req_ready stays 0 for all requesters; release completes next cycle.
5. **Async reset mid-operation.**
   - Stimulus: assert rst between clock edges while in EXEC.
   - Required: all outputs 0 immediately; no rsp_valid after reset release; ptr=0, so requester 0 wins the next contention.
6. **Locked requester idle.**
   - Stimulus: lock held by requester 1, which drops req_valid while requester 0 is valid for 10 cycles.
   - Required: no grant to requester 0; req_ready=0 throughout.
